// File: rtl/booth_mul_arbiter_if.sv
// Shared-multiplier bus between the arbiter (master) and the single Booth multiplier (slave).
interface booth_mul_arbiter_if #(
    parameter int DATA_SIZE = 8
);
    logic                   enable;
    logic [DATA_SIZE-1:0]   multiplicand;
    logic [DATA_SIZE-1:0]   multiplier;
    logic                   data_valid;
    logic [2*DATA_SIZE-1:0] product;

    modport master (
        output enable, multiplicand, multiplier,
        input  data_valid, product
    );

    modport slave (
        input  enable, multiplicand, multiplier,
        output data_valid, product
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one Booth multiplier among NUM_REQ clients.
// Define BOOTH_ARB_TIMEOUT_EN to add the WAIT-state watchdog that drives error_o.
module booth_mul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   multiplicand_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   multiplier_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic [2*DATA_SIZE-1:0]         product_o,
    output logic                           busy_o,
    output logic                           error_o,
    booth_mul_arbiter_if.master            mul
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("booth_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic [2*DATA_SIZE-1:0] r_product;
    logic                   r_busy;
    logic                   r_enable;
    logic [DATA_SIZE-1:0]   r_opa;
    logic [DATA_SIZE-1:0]   r_opb;

    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W-1:0]       w_cand;
    logic [DATA_SIZE-1:0]   w_opa;
    logic [DATA_SIZE-1:0]   w_opb;

    // Search upward from the pointer, wrapping; the first requester found wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        w_opa    = '0;
        w_opb    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(r_ptr) + i >= NUM_REQ) ? IDX_W'(int'(r_ptr) + i - NUM_REQ)
                                                  : IDX_W'(int'(r_ptr) + i);
            if (!w_found && req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == IDX_W'(k)) begin
                w_opa = multiplicand_i[k*DATA_SIZE +: DATA_SIZE];
                w_opb = multiplier_i[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_error;
`endif

    // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_enable  <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_enable <= 1'b0;
            r_done   <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            r_error  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_ISSUE;
                        r_idx    <= w_winner;
                        r_grant  <= NUM_REQ'(1) << w_winner;
                        r_opa    <= w_opa;
                        r_opb    <= w_opb;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // A valid in the limit cycle takes priority over the watchdog.
                    if (mul.data_valid) begin
                        r_product <= mul.product;
                        r_done    <= r_grant;
                        r_state   <= S_RESP;
                    end
`ifdef BOOTH_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_product <= '0;
                        r_done    <= r_grant;
                        r_error   <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_o          = r_grant;
    assign done_o           = r_done;
    assign product_o        = r_product;
    assign busy_o           = r_busy;
    assign mul.enable       = r_enable;
    assign mul.multiplicand = r_opa;
    assign mul.multiplier   = r_opb;

`ifdef BOOTH_ARB_TIMEOUT_EN
    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a latency-programmable signed multiplier model.
module tb_booth_mul_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    typedef struct packed {
        logic [N-1:0]   done;
        logic [2*D-1:0] product;
        logic           error;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_ni;
    logic [N-1:0]   req;
    logic [N*D-1:0] mcand;
    logic [N*D-1:0] mplier;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [2*D-1:0] product;
    logic           busy;
    logic           error;

    booth_mul_arbiter_if #(.DATA_SIZE(D)) mul_bus ();

    booth_mul_arbiter #(
        .NUM_REQ(N),
        .DATA_SIZE(D),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_ni),
        .req_i(req),
        .multiplicand_i(mcand),
        .multiplier_i(mplier),
        .grant_o(grant),
        .done_o(done),
        .product_o(product),
        .busy_o(busy),
        .error_o(error),
        .mul(mul_bus.master)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_enable = 0;
    int   cyc_cnt  = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [2*D-1:0] smul(input logic [D-1:0] a, input logic [D-1:0] b);
        logic signed [2*D-1:0] sa;
        logic signed [2*D-1:0] sb_v;
        sa   = {{D{a[D-1]}}, a};
        sb_v = {{D{b[D-1]}}, b};
        return sa * sb_v;
    endfunction

    // Multiplier model: valid arrives lat cycles after the enable is seen.
    int             lat  = 4;
    logic           mute = 1'b0;
    logic           stray = 1'b0;
    logic           m_busy;
    logic           m_valid;
    int             m_cnt;
    logic [2*D-1:0] m_res;

    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else begin
            m_valid <= 1'b0;
            if (mul_bus.enable) begin
                m_busy <= 1'b1;
                m_cnt  <= lat - 1;
                m_res  <= smul(mul_bus.multiplicand, mul_bus.multiplier);
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_valid <= !mute;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign mul_bus.data_valid = m_valid | stray;
    assign mul_bus.product    = stray ? 16'hDEAD : m_res;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (reset_ni === 1'b1 && mul_bus.enable === 1'b1) n_enable <= n_enable + 1;
    end

    // Every done pulse is matched against the next expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (reset_ni === 1'b1 && done !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                check("done",    32'(done),    32'(e.done));
                check("grant",   32'(grant),   32'(e.done));
                check("product", 32'(product), 32'(e.product));
                check("error",   32'(error),   32'(e.error));
            end
        end
    end

    task automatic set_ops(input int k, input logic [D-1:0] a, input logic [D-1:0] b);
        mcand  = (mcand  & ~(32'hFF << (k*D))) | (32'(a) << (k*D));
        mplier = (mplier & ~(32'hFF << (k*D))) | (32'(b) << (k*D));
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] seen);
        seen = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                seen = done;
                return;
            end
        end
        check("done_wait_expired", 32'h1, 32'h0);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        req      = '0;
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_done"},  32'(done),  32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_error"}, 32'(error), 32'h0);
        check({tag, "_en"},    32'(mul_bus.enable), 32'h0);
        check({tag, "_prod"},  32'(product), 32'h0);
        check({tag, "_opa"},   32'(mul_bus.multiplicand), 32'h0);
        check({tag, "_opb"},   32'(mul_bus.multiplier), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seen;
        int t0;
        int e0;

        reset_ni = 1'b0;
        req      = '0;
        mcand    = '0;
        mplier   = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk);
        #1;

        // Single request: 3 x -2 with an 18-cycle multiplier.
        lat = 18;
        set_ops(0, 8'h03, 8'hFE);
        sb.push_back('{4'b0001, 16'hFFFA, 1'b0});
        e0  = n_enable;
        t0  = cyc_cnt;
        req = 4'b0001;
        @(negedge clk);
        check("t1_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        check("t1_issue_en",    32'(mul_bus.enable), 32'h1);
        check("t1_issue_grant", 32'(grant), 32'h1);
        check("t1_issue_busy",  32'(busy), 32'h1);
        check("t1_opa",         32'(mul_bus.multiplicand), 32'h03);
        check("t1_opb",         32'(mul_bus.multiplier), 32'hFE);
        @(negedge clk);
        check("t1_wait_en",     32'(mul_bus.enable), 32'h0);
        check("t1_wait_grant",  32'(grant), 32'h1);
        wait_done(40, seen);
        check("t1_latency", 32'(cyc_cnt - t0), 32'd21);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        check("t1_idle_busy",  32'(busy), 32'h0);
        check("t1_idle_grant2", 32'(grant), 32'h0);
        check("t1_enables", 32'(n_enable - e0), 32'd1);

        // All four held: service order 0,1,2,3,0.
        do_reset();
        lat = 3;
        for (int k = 0; k < N; k++) set_ops(k, 8'(k + 1), 8'h02);
        sb.push_back('{4'b0001, 16'h0002, 1'b0});
        sb.push_back('{4'b0010, 16'h0004, 1'b0});
        sb.push_back('{4'b0100, 16'h0006, 1'b0});
        sb.push_back('{4'b1000, 16'h0008, 1'b0});
        sb.push_back('{4'b0001, 16'h0002, 1'b0});
        e0  = n_enable;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_done(20, seen);
        @(posedge clk);
        #1 req = '0;
        repeat (3) @(negedge clk);
        check("t2_enables", 32'(n_enable - e0), 32'd5);
        check("t2_idle_busy", 32'(busy), 32'h0);

        // Pointer wrap: serve 2, then 1 and 3 together -> 3 before 1.
        do_reset();
        lat = 2;
        set_ops(2, 8'h05, 8'h07);
        set_ops(1, 8'h10, 8'h10);
        set_ops(3, 8'hFF, 8'hFF);
        sb.push_back('{4'b0100, 16'h0023, 1'b0});
        sb.push_back('{4'b1000, 16'h0001, 1'b0});
        sb.push_back('{4'b0010, 16'h0100, 1'b0});
        req = 4'b0100;
        wait_done(20, seen);
        @(posedge clk);
        #1 req = 4'b1010;
        wait_done(20, seen);
        check("t3_first", 32'(seen), 32'b1000);
        @(posedge clk);
        #1 req = req & ~seen;
        wait_done(20, seen);
        @(posedge clk);
        #1 req = req & ~seen;

        // Request withdrawn during WAIT still completes, with no re-issue.
        lat = 10;
        set_ops(1, 8'h7F, 8'h80);
        sb.push_back('{4'b0010, 16'hC080, 1'b0});
        e0  = n_enable;
        req = 4'b0010;
        repeat (4) @(posedge clk);
        #1 req = '0;
        wait_done(30, seen);
        repeat (6) @(negedge clk);
        check("t4_enables", 32'(n_enable - e0), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'h0);

        // Stray valid in IDLE and in ISSUE is ignored.
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        check("t5_idle_stray_prod", 32'(product), 32'hC080);
        lat = 5;
        set_ops(2, 8'h02, 8'h03);
        sb.push_back('{4'b0100, 16'h0006, 1'b0});
        req = 4'b0100;
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        check("t5_issue_stray_prod", 32'(product), 32'hC080);
        check("t5_issue_stray_busy", 32'(busy), 32'h1);
        wait_done(20, seen);
        @(posedge clk);
        #1 req = '0;

        // Reset mid-WAIT aborts with no done and returns the pointer to 0.
        lat = 20;
        set_ops(0, 8'h09, 8'h09);
        req = 4'b0001;
        repeat (6) @(posedge clk);
        #1 reset_ni = 1'b0;
        req = '0;
        #1;
        check_reset_outputs("t6_abort");
        @(posedge clk);
        #1 reset_ni = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_after_busy", 32'(busy), 32'h0);
        lat = 1;
        set_ops(1, 8'h04, 8'h05);
        set_ops(3, 8'h06, 8'h07);
        sb.push_back('{4'b0010, 16'h0014, 1'b0});
        sb.push_back('{4'b1000, 16'h002A, 1'b0});
        @(posedge clk);
        #1 req = 4'b1010;
        wait_done(20, seen);
        check("t6_ptr_first", 32'(seen), 32'b0010);
        @(posedge clk);
        #1 req = req & ~seen;
        wait_done(20, seen);
        @(posedge clk);
        #1 req = req & ~seen;

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Silent multiplier: watchdog fires after 32 WAIT cycles, then normal service resumes.
        lat  = 4;
        mute = 1'b1;
        set_ops(2, 8'h03, 8'h03);
        sb.push_back('{4'b0100, 16'h0000, 1'b1});
        t0  = cyc_cnt;
        req = 4'b0100;
        wait_done(60, seen);
        check("t7_timeout_latency", 32'(cyc_cnt - t0), 32'd34);
        @(posedge clk);
        #1 req = '0;
        mute = 1'b0;
        lat  = 3;
        set_ops(0, 8'h04, 8'h04);
        sb.push_back('{4'b0001, 16'h0010, 1'b0});
        @(posedge clk);
        #1 req = 4'b0001;
        wait_done(20, seen);
        @(posedge clk);
        #1 req = '0;
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
